// File: rtl/access_port_controller_pkg.sv
// Shared widths, FSM state encoding and request-entry layout for the access port controller.
package access_port_controller_pkg;

    localparam int NETWORK_ADDRESS_WIDTH    = 4;
    localparam int CACHE_BANK_ADDRESS_WIDTH = 4;
    localparam int DATA_WIDTH               = 32;
    localparam int ADDR_WIDTH               = NETWORK_ADDRESS_WIDTH + CACHE_BANK_ADDRESS_WIDTH;
    localparam int REQ_ENTRY_WIDTH          = 1 + ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic [2:0] {
        ACP_IDLE    = 3'd0,
        ACP_ISSUE   = 3'd1,
        ACP_WAIT    = 3'd2,
        ACP_GAP     = 3'd3,
        ACP_RESPOND = 3'd4
    } acp_state_t;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } req_entry_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/access_port_controller_fifo.sv
// Synchronous single-clock request FIFO; pointers carry one extra wrap bit to tell full from empty.
module request_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                   (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[IDX_W-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[IDX_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/access_port_controller.sv
// Client front end for one network access port: queues requests, issues them one at a time,
// and returns read data (or a timeout error) through a valid/ready response channel.
module access_port_controller
    import access_port_controller_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int WRITE_GAP      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_error,
    output logic [ADDR_WIDTH-1:0] destinationAddressOut,
    output logic                  readOut,
    output logic                  writeOut,
    output logic [DATA_WIDTH-1:0] dataOut,
    input  logic                  readReady,
    input  logic [DATA_WIDTH-1:0] dataIn,
    output logic [7:0]            timeout_count
);
    acp_state_t                 state;
    acp_state_t                 state_next;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       fifo_pop;
    logic [REQ_ENTRY_WIDTH-1:0] fifo_head_raw;
    req_entry_t                 fifo_head;
    logic                       cur_write;
    logic [15:0]                cnt;
    logic                       gap_done;
    logic                       wait_expired;

    assign req_ready = !fifo_full;
    assign fifo_pop  = (state == ACP_IDLE) && !fifo_empty;
    assign fifo_head = req_entry_t'(fifo_head_raw);

    request_fifo #(
        .WIDTH (REQ_ENTRY_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_request_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (req_valid && req_ready),
        .push_data ({req_write, req_addr, req_data}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head_raw),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // One shared counter: GAP spacing for writes, reply timeout for reads.
    assign gap_done     = (cnt == 16'(WRITE_GAP - 1));
    assign wait_expired = (cnt == 16'(TIMEOUT_CYCLES - 1));

    assign readOut   = (state == ACP_ISSUE) && !cur_write;
    assign writeOut  = (state == ACP_ISSUE) && cur_write;
    assign rsp_valid = (state == ACP_RESPOND);

    always_comb begin
        state_next = state;
        case (state)
            ACP_IDLE:    if (!fifo_empty) state_next = ACP_ISSUE;
            ACP_ISSUE:   state_next = cur_write ? ACP_GAP : ACP_WAIT;
            ACP_GAP:     if (gap_done) state_next = ACP_IDLE;
            ACP_WAIT:    if (readReady || wait_expired) state_next = ACP_RESPOND;
            ACP_RESPOND: if (rsp_ready) state_next = ACP_IDLE;
            default:     state_next = ACP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= ACP_IDLE;
            cur_write             <= 1'b0;
            cnt                   <= '0;
            destinationAddressOut <= '0;
            dataOut               <= '0;
            rsp_data              <= '0;
            rsp_error             <= 1'b0;
            timeout_count         <= '0;
        end else begin
            state <= state_next;
            case (state)
                ACP_IDLE: begin
                    if (fifo_pop) begin
                        cur_write             <= fifo_head.write;
                        destinationAddressOut <= fifo_head.addr;
                        dataOut               <= fifo_head.data;
                    end
                end
                ACP_ISSUE: cnt <= '0;
                ACP_GAP:   cnt <= cnt + 16'd1;
                ACP_WAIT: begin
                    // Data beats the timeout when both land in the same cycle.
                    if (readReady) begin
                        rsp_data  <= dataIn;
                        rsp_error <= 1'b0;
                    end else if (wait_expired) begin
                        rsp_data      <= '0;
                        rsp_error     <= 1'b1;
                        timeout_count <= sat_inc8(timeout_count);
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
